// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported word
// memory. Each accepted command occupies the memory for exactly one cycle,
// driven from a command register. Read data is registered back to the port
// that issued the command.
//
// Handshake: a port holds pX_req with a stable command until it sees pX_gnt.
// The arbiter samples req at every rising edge. A winning port gets a single
// pX_gnt pulse in the following cycle, and the memory command runs in that
// same cycle. If req is still high at the next edge, that is a new command.
// Reads return pX_rvalid for one cycle, one cycle after gnt. Writes return no
// response.
module mem_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [AddrWidth-1:0] p0_addr,
  input  logic [DataWidth-1:0] p0_wdata,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [DataWidth-1:0] p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [AddrWidth-1:0] p1_addr,
  input  logic [DataWidth-1:0] p1_wdata,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [DataWidth-1:0] p1_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  // Command register: the command that owns the memory this cycle.
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_port_q,  cmd_port_d;
  logic                 cmd_we_q,    cmd_we_d;
  logic [AddrWidth-1:0] cmd_addr_q,  cmd_addr_d;
  logic [DataWidth-1:0] cmd_wdata_q, cmd_wdata_d;

  // Round-robin pointer: the most recent winner. It resets to 1, so port 0
  // wins the first contention.
  logic                 last_q, last_d;

  // Registered grant and response outputs.
  logic                 p0_gnt_q, p0_gnt_d;
  logic                 p1_gnt_q, p1_gnt_d;
  logic                 p0_rvalid_q, p0_rvalid_d;
  logic                 p1_rvalid_q, p1_rvalid_d;
  logic [DataWidth-1:0] p0_rdata_q, p0_rdata_d;
  logic [DataWidth-1:0] p1_rdata_q, p1_rdata_d;

  logic win0, win1, rd_fire;

  // Arbitration: a lone requester wins; on contention the port that did not
  // win last time wins.
  always_comb begin
    win0 = p0_req & (~p1_req | last_q);
    win1 = p1_req & (~p0_req | ~last_q);
  end

  // Next-state logic for the command register, the grants and the responses.
  always_comb begin
    cmd_valid_d = win0 | win1;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    last_d      = last_q;
    if (win0) begin
      cmd_port_d  = 1'b0;
      cmd_we_d    = p0_we;
      cmd_addr_d  = p0_addr;
      cmd_wdata_d = p0_wdata;
      last_d      = 1'b0;
    end else if (win1) begin
      cmd_port_d  = 1'b1;
      cmd_we_d    = p1_we;
      cmd_addr_d  = p1_addr;
      cmd_wdata_d = p1_wdata;
      last_d      = 1'b1;
    end
    p0_gnt_d = win0;
    p1_gnt_d = win1;

    // A read in its command cycle returns memory data to the port that issued it.
    rd_fire     = cmd_valid_q & ~cmd_we_q;
    p0_rvalid_d = rd_fire & ~cmd_port_q;
    p1_rvalid_d = rd_fire &  cmd_port_q;
    p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
    p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
  end

  // State registers. Reset clears cmd_valid at once, so a write in flight
  // is dropped before it can commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      last_q      <= 1'b1;
      p0_gnt_q    <= 1'b0;
      p1_gnt_q    <= 1'b0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      last_q      <= last_d;
      p0_gnt_q    <= p0_gnt_d;
      p1_gnt_q    <= p1_gnt_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  assign mem_read  = cmd_valid_q & ~cmd_we_q;
  assign mem_write = cmd_valid_q &  cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;

  assign p0_gnt    = p0_gnt_q;
  assign p1_gnt    = p1_gnt_q;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It contains a small word-memory model, directed
// stimulus, and per-port scoreboards of expected read data.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] ref_mem [0:63];

  // Memory model: 64 words, decoded from addr[7:2].
  logic [DW-1:0] mem [0:63];
  logic          pre_we;
  logic [5:0]    pre_idx;
  logic [DW-1:0] pre_val;

  mem_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory writes: bench preload first, otherwise arbiter writes.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [DW-1:0] val);
    pre_we = 1'b1; pre_idx = idx[5:0]; pre_val = val;
    ref_mem[idx] = val;
    step();
    pre_we = 1'b0;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, {p0_gnt, p1_gnt}, 0);
    chk({tag, "_rvalid"}, {p0_rvalid, p1_rvalid}, 0);
    chk({tag, "_memrw"}, {mem_read, mem_write}, 0);
    chk({tag, "_rdata"}, {p0_rdata, p1_rdata}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  // Scoreboard: every rvalid pulse pops the expected word for its port.
  always @(negedge clk) begin
    if (p0_rvalid === 1'b1) begin
      if (exp0_q.size() == 0) chk("p0_rvalid_unexpected", p0_rvalid, 0);
      else chk("p0_rdata_sb", p0_rdata, exp0_q.pop_front());
    end
    if (p1_rvalid === 1'b1) begin
      if (exp1_q.size() == 0) chk("p1_rvalid_unexpected", p1_rvalid, 0);
      else chk("p1_rdata_sb", p1_rdata, exp1_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    preload(0, 32'h1111_0000);
    preload(1, 32'h2222_1111);
    preload(2, 32'hDEAD_BEEF);
    preload(3, 32'h3333_2222);
    preload(4, 32'h0000_0000);
    preload(5, 32'hAAAA_AAAA);
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single read of word 2 by port 0.
    drive0(1, 0, 32'h8, '0);
    exp0_q.push_back(ref_mem[2]);
    step();
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_p1_gnt", p1_gnt, 0);
    chk("rd_mem_read", mem_read, 1);
    chk("rd_mem_addr", mem_addr, 32'h8);
    drive0(0, 0, '0, '0);
    step();
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("rd_p1_rvalid", p1_rvalid, 0);
    chk("rd_p1_rdata_hold", p1_rdata, 0);
    step();

    // Port 1 writes word 4, then reads it back in the next cycle.
    drive1(1, 1, 32'h10, 32'h1234_5678);
    ref_mem[4] = 32'h1234_5678;
    step();
    chk("wr_p1_gnt", p1_gnt, 1);
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    drive1(1, 0, 32'h10, '0);
    exp1_q.push_back(ref_mem[4]);
    step();
    chk("wr_rd_p1_gnt", p1_gnt, 1);
    chk("wr_rd_mem_read", mem_read, 1);
    drive1(0, 0, '0, '0);
    step();
    chk("wr_rd_p1_rvalid", p1_rvalid, 1);
    chk("wr_rd_p1_rdata", p1_rdata, 32'h1234_5678);
    chk("wr_rd_p0_rdata_hold", p0_rdata, 32'hDEAD_BEEF);
    step();

    // Both ports hold reads for four edges; grants alternate starting with p0.
    drive0(1, 0, 32'h0, '0);
    drive1(1, 0, 32'h4, '0);
    exp0_q.push_back(ref_mem[0]); exp0_q.push_back(ref_mem[0]);
    exp1_q.push_back(ref_mem[1]); exp1_q.push_back(ref_mem[1]);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("cont_gnt_%0d", i), {p0_gnt, p1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    drive0(0, 0, '0, '0);
    drive1(0, 0, '0, '0);
    step(); step();

    // Back-to-back reads by port 0 of words 0..3.
    for (int i = 0; i < 4; i++) begin
      drive0(1, 0, 32'(i * 4), '0);
      exp0_q.push_back(ref_mem[i]);
      step();
      chk($sformatf("b2b_gnt_%0d", i), p0_gnt, 1);
      if (i > 0) chk($sformatf("b2b_rvalid_%0d", i), p0_rvalid, 1);
    end
    drive0(0, 0, '0, '0);
    step();
    chk("b2b_rvalid_last", p0_rvalid, 1);
    step();
    chk("b2b_rvalid_done", p0_rvalid, 0);

    // Reset lands in a write's command cycle; the write must not commit.
    drive0(1, 1, 32'h14, 32'h5555_5555);
    step();
    chk("rst_wr_mem_write", mem_write, 1);
    drive0(0, 0, '0, '0);
    #2 rst_n = 1'b0;
    #1 chk("rst_wr_dropped", mem_write, 0);
    step();
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    step();

    // First contention after reset goes to p0; the loser wins next.
    drive0(1, 0, 32'h14, '0);
    drive1(1, 0, 32'h8, '0);
    exp0_q.push_back(ref_mem[5]);
    exp1_q.push_back(ref_mem[2]);
    step();
    chk("post_rst_gnt_p0", {p0_gnt, p1_gnt}, 2'b10);
    drive0(0, 0, '0, '0);
    step();
    chk("post_rst_gnt_p1", {p0_gnt, p1_gnt}, 2'b01);
    chk("post_rst_p0_rdata", p0_rdata, 32'hAAAA_AAAA);
    drive1(0, 0, '0, '0);
    step(); step(); step();

    chk("sb_p0_empty", exp0_q.size(), 0);
    chk("sb_p1_empty", exp1_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
